mul_io_sequencer: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 33 +++
 rtl/mul_seq_acc.sv | 41 ++++
 rtl/mul_io_sequencer.sv | 95 +++++++++
 tb/tb_mul_io_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and the saturating-add helper for the multiplier sequencing stage.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        OUT  = 2'b10
    } state_t;

    localparam int unsigned MAX_W = 32;

    // All-ones at the widest supported accumulator; narrowed by shifting to the active width.
    localparam logic [MAX_W-1:0] ACC_MAX = '1;

    function automatic logic [MAX_W-1:0] sat_add(
        input  logic [MAX_W-1:0] acc,
        input  logic [MAX_W-1:0] addend,
        input  int unsigned      width,
        output logic             ovf
    );
        logic [MAX_W:0] sum;
        logic [MAX_W:0] limit;
        sum   = {1'b0, acc} + {1'b0, addend};
        limit = {1'b0, ACC_MAX >> (MAX_W - width)};
        if (sum > limit) begin
            ovf = 1'b1;
            return limit[MAX_W-1:0];
        end
        ovf = 1'b0;
        return sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mul_seq_acc.sv
// Result register: overwrites with, or saturating-accumulates, the multiplier product on load.
module mul_seq_acc
    import mul_seq_pkg::*;
#(
    parameter int unsigned BITS  = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              mode,
    input  logic [2*BITS-1:0] product,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [ACC_W-1:0] acc_d;
    logic             ovf_d;

    always_comb begin
        acc_d = acc;
        ovf_d = ovf;
        if (mode) begin
            acc_d = ACC_W'(sat_add(MAX_W'(acc), MAX_W'(product), ACC_W, ovf_d));
        end else begin
            acc_d = ACC_W'(product);
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            acc <= acc_d;
            ovf <= ovf_d;
        end
    end

endmodule

// File: rtl/mul_io_sequencer.sv
// Handshaked sequencer that feeds registered operands to an external multiplier
// and returns the overwritten or saturating-accumulated product downstream.
module mul_io_sequencer
    import mul_seq_pkg::*;
#(
    parameter int unsigned BITS  = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    input  logic              in_acc,
    output logic [BITS-1:0]   mul_a,
    output logic [BITS-1:0]   mul_b,
    input  logic [2*BITS-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_result,
    output logic              out_ovf
);

    state_t state, state_d;
    logic   acc_mode;
    logic   accept;
    logic   load;
    logic   valid_d;

    assign in_ready = ena && (state == IDLE);

    always_comb begin
        state_d = state;
        valid_d = out_valid;
        accept  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                load    = 1'b1;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            acc_mode  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ena) begin
            state     <= state_d;
            out_valid <= valid_d;
            if (accept) begin
                mul_a    <= in_a;
                mul_b    <= in_b;
                acc_mode <= in_acc;
            end
        end
    end

    mul_seq_acc #(
        .BITS  (BITS),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ena && load),
        .mode    (acc_mode),
        .product (mul_product),
        .acc     (out_result),
        .ovf     (out_ovf)
    );

endmodule

// File: tb/tb_mul_io_sequencer.sv
// Self-checking bench for mul_io_sequencer with a behavioural multiplier and result model.
module tb_mul_io_sequencer;

    localparam int unsigned BITS    = 4;
    localparam int unsigned ACC_W   = 12;
    localparam int unsigned RES_MAX = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              in_valid;
    logic              in_ready;
    logic [BITS-1:0]   in_a;
    logic [BITS-1:0]   in_b;
    logic              in_acc;
    logic [BITS-1:0]   mul_a;
    logic [BITS-1:0]   mul_b;
    logic [2*BITS-1:0] mul_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_result;
    logic              out_ovf;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned model_acc = 0;
    logic        model_ovf = 1'b0;
    int unsigned last_a = 0;
    int unsigned last_b = 0;

    always #5 clk = ~clk;

    // Stand-in for the external combinational multiplier.
    assign mul_product = (2*BITS)'(mul_a) * (2*BITS)'(mul_b);

    mul_io_sequencer #(
        .BITS  (BITS),
        .ACC_W (ACC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_acc      (in_acc),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_op(input int unsigned a, input int unsigned b, input bit accm);
        int unsigned p;
        p = a * b;
        if (accm) begin
            if (model_acc + p > RES_MAX) begin
                model_acc = RES_MAX;
                model_ovf = 1'b1;
            end else begin
                model_acc = model_acc + p;
                model_ovf = 1'b0;
            end
        end else begin
            model_acc = p;
            model_ovf = 1'b0;
        end
    endtask

    // Called just after a negedge with the DUT idle; returns with the result presented.
    task automatic op_start(input int unsigned a, input int unsigned b, input bit accm, input bit gate);
        logic [ACC_W-1:0] prev_result;
        check("idle_in_ready", 32'(in_ready), 1);
        prev_result = out_result;
        in_valid = 1'b1;
        in_a     = BITS'(a);
        in_b     = BITS'(b);
        in_acc   = accm;
        last_a   = a;
        last_b   = b;
        model_op(a, b, accm);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = BITS'($urandom_range(0, 15));
        in_b     = BITS'($urandom_range(0, 15));
        in_acc   = 1'($urandom_range(0, 1));
        check("mul_a_captured", 32'(mul_a), a);
        check("mul_b_captured", 32'(mul_b), b);
        check("calc_valid_low", 32'(out_valid), 0);
        check("calc_in_ready", 32'(in_ready), 0);
        if (gate) begin
            ena = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("gated_in_ready", 32'(in_ready), 0);
                check("gated_mul_a", 32'(mul_a), a);
                check("gated_mul_b", 32'(mul_b), b);
                check("gated_valid", 32'(out_valid), 0);
                check("gated_result", 32'(out_result), 32'(prev_result));
            end
            ena = 1'b1;
            @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
        end
        check("out_valid", 32'(out_valid), 1);
        check("out_result", 32'(out_result), model_acc);
        check("out_ovf", 32'(out_ovf), 32'(model_ovf));
    endtask

    task automatic op_finish(input int unsigned stall);
        for (int unsigned i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a     = 4'd7;
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_result", 32'(out_result), model_acc);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_mul_a", 32'(mul_a), last_a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("done_valid", 32'(out_valid), 0);
        check("done_in_ready", 32'(in_ready), 1);
        check("done_mul_a", 32'(mul_a), last_a);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 4'd9;
        in_b      = 4'd9;
        in_acc    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_result", 32'(out_result), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        check("rst_ovf", 32'(out_ovf), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Overwrite with backpressure and ignored operands during OUT.
        op_start(3, 5, 1'b0, 1'b0);
        check("basic_15", 32'(out_result), 15);
        op_finish(5);

        // Saturating accumulation.
        op_start(15, 15, 1'b0, 1'b0);
        op_finish(0);
        for (int i = 0; i < 17; i++) begin
            op_start(15, 15, 1'b1, 1'b0);
            op_finish(0);
        end
        check("sat_4050", 32'(out_result), 4050);
        op_start(15, 15, 1'b1, 1'b0);
        check("sat_4095", 32'(out_result), 4095);
        check("sat_ovf", 32'(out_ovf), 1);
        op_finish(1);
        op_start(2, 2, 1'b0, 1'b0);
        check("clear_4", 32'(out_result), 4);
        check("clear_ovf", 32'(out_ovf), 0);
        op_finish(0);

        // Enable gating while in CALC.
        op_start(6, 7, 1'b0, 1'b1);
        check("gate_42", 32'(out_result), 42);
        op_finish(2);

        // Reset while presenting a result.
        op_start(3, 5, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_acc = 0;
        model_ovf = 1'b0;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_result", 32'(out_result), 0);
        check("midrst_mul_a", 32'(mul_a), 0);
        op_start(2, 3, 1'b1, 1'b0);
        check("midrst_acc_6", 32'(out_result), 6);
        op_finish(0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            op_start($urandom_range(0, 15), $urandom_range(0, 15),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            op_finish($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
